// File: rtl/uart_mmio_arbiter.sv
// rtl/uart_mmio_arbiter.sv - round-robin sharing of one UART MMIO slave with TX-busy pacing
module uart_mmio_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_r0_req,
  input  logic        i_r0_we,
  input  logic [31:0] i_r0_addr,
  input  logic [7:0]  i_r0_wdata,
  output logic        o_r0_ack,
  output logic [7:0]  o_r0_rdata,
  output logic        o_r0_err,
  input  logic        i_r1_req,
  input  logic        i_r1_we,
  input  logic [31:0] i_r1_addr,
  input  logic [7:0]  i_r1_wdata,
  output logic        o_r1_ack,
  output logic [7:0]  o_r1_rdata,
  output logic        o_r1_err,
  output logic [31:0] o_mmio_addr,
  output logic [7:0]  o_mmio_wdata,
  input  logic [7:0]  i_mmio_rdata,
  output logic        o_mmio_we,
  output logic        o_mmio_re
);

  localparam logic [31:0] TX_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd8;
  localparam int          CW        = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, POLL_ISSUE, POLL_WAIT, WR_ISSUE, RESP
  } state_t;

  state_t        state, state_nx;
  // last_grant doubles as the owner of the transaction in flight
  logic          last_grant, last_grant_nx;
  logic [31:0]   lat_addr, addr_nx;
  logic [7:0]    lat_wdata, wdata_nx;
  logic [CW-1:0] poll_cnt, poll_cnt_nx;
  logic          limit_hit;
  logic          sel, sel_we;
  logic [31:0]   sel_addr;
  logic [7:0]    sel_wdata;
  logic          mmio_re_nx, mmio_we_nx;
  logic [31:0]   mmio_addr_nx;
  logic [7:0]    mmio_wdata_nx;

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    addr_nx       = lat_addr;
    wdata_nx      = lat_wdata;
    poll_cnt_nx   = poll_cnt;
    limit_hit     = 1'b0;
    sel           = (i_r0_req && i_r1_req) ? ~last_grant : i_r1_req;
    sel_we        = sel ? i_r1_we : i_r0_we;
    sel_addr      = sel ? i_r1_addr : i_r0_addr;
    sel_wdata     = sel ? i_r1_wdata : i_r0_wdata;
    case (state)
      IDLE: begin
        if (i_r0_req || i_r1_req) begin
          last_grant_nx = sel;
          addr_nx       = sel_addr;
          wdata_nx      = sel_wdata;
          poll_cnt_nx   = '0;
          if (!sel_we) begin
            state_nx = RD_ISSUE;
          end else if (sel_addr == TX_ADDR) begin
            state_nx = POLL_ISSUE;
          end else begin
            state_nx = WR_ISSUE;
          end
        end
      end
      RD_ISSUE:   state_nx = RD_WAIT;
      RD_WAIT:    state_nx = RESP;
      POLL_ISSUE: state_nx = POLL_WAIT;
      POLL_WAIT: begin
        if (!i_mmio_rdata[1]) begin
          state_nx = WR_ISSUE;
        end else if (32'(poll_cnt) + 32'd1 < 32'(POLL_LIMIT)) begin
          poll_cnt_nx = poll_cnt + CW'(1);
          state_nx    = POLL_ISSUE;
        end else begin
          limit_hit = 1'b1;
          state_nx  = RESP;
        end
      end
      WR_ISSUE:   state_nx = RESP;
      RESP:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase

    // Slave-side outputs are registered, so they are decoded from the state being entered
    mmio_re_nx    = (state_nx == RD_ISSUE) || (state_nx == POLL_ISSUE);
    mmio_we_nx    = (state_nx == WR_ISSUE);
    mmio_addr_nx  = '0;
    if ((state_nx == RD_ISSUE) || (state_nx == WR_ISSUE)) begin
      mmio_addr_nx = addr_nx;
    end else if (state_nx == POLL_ISSUE) begin
      mmio_addr_nx = STAT_ADDR;
    end
    mmio_wdata_nx = (state_nx == WR_ISSUE) ? wdata_nx : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      poll_cnt     <= '0;
      o_mmio_addr  <= '0;
      o_mmio_wdata <= '0;
      o_mmio_we    <= 1'b0;
      o_mmio_re    <= 1'b0;
      o_r0_ack     <= 1'b0;
      o_r0_rdata   <= '0;
      o_r0_err     <= 1'b0;
      o_r1_ack     <= 1'b0;
      o_r1_rdata   <= '0;
      o_r1_err     <= 1'b0;
    end else begin
      state        <= state_nx;
      last_grant   <= last_grant_nx;
      lat_addr     <= addr_nx;
      lat_wdata    <= wdata_nx;
      poll_cnt     <= poll_cnt_nx;
      o_mmio_addr  <= mmio_addr_nx;
      o_mmio_wdata <= mmio_wdata_nx;
      o_mmio_we    <= mmio_we_nx;
      o_mmio_re    <= mmio_re_nx;
      o_r0_ack     <= (state_nx == RESP) && !last_grant_nx;
      o_r1_ack     <= (state_nx == RESP) && last_grant_nx;
      if (state == RD_WAIT) begin
        if (last_grant) o_r1_rdata <= i_mmio_rdata;
        else            o_r0_rdata <= i_mmio_rdata;
      end
      if (state_nx == RESP) begin
        if (last_grant) o_r1_err <= limit_hit;
        else            o_r0_err <= limit_hit;
      end
    end
  end

endmodule
